// File: rtl/mem_stage.sv
// mem_stage: data-memory pipeline stage between execute and write-back.
// Single-entry stage: accepts one instruction, performs its load/store over a
// req/ack bus when needed, then holds the result until write-back takes it.
module mem_stage #(
   parameter int unsigned BITSIZE = 32
) (
   input  logic               clk,
   input  logic               resetn_i,
   // execute side
   input  logic               EX_MEM_give_i,
   output logic               MEM_EX_get_o,
   input  logic [31:0]        EX_MEM_instruction_i,
   input  logic [BITSIZE-1:0] EX_MEM_result_i,
   input  logic [BITSIZE-1:0] EX_MEM_rs2_i,
   // write-back side
   output logic               MEM_WB_give_o,
   input  logic               WB_MEM_get_i,
   output logic [31:0]        MEM_WB_instruction_o,
   output logic [BITSIZE-1:0] MEM_WB_data_o,
   // data memory bus
   output logic               mem_req_o,
   output logic               mem_we_o,
   output logic [BITSIZE-1:0] mem_addr_o,
   output logic [BITSIZE-1:0] mem_wdata_o,
   output logic [3:0]         mem_be_o,
   input  logic [BITSIZE-1:0] mem_rdata_i,
   input  logic               mem_ack_i
);

   localparam int unsigned OPC_W   = 7;
   localparam int unsigned F3_W    = 3;
   localparam int unsigned BE_W    = 4;
   localparam logic [OPC_W-1:0] OPC_LOAD  = 7'b0000011;
   localparam logic [OPC_W-1:0] OPC_STORE = 7'b0100011;

   typedef enum logic [1:0] {
      ST_GET    = 2'd0,
      ST_ACCESS = 2'd1,
      ST_GIVE   = 2'd2
   } state_e;

   state_e state_q, state_d;

   logic               get_q, get_d;
   logic               give_q, give_d;
   logic               req_q, req_d;
   logic               we_q, we_d;
   logic [BE_W-1:0]    be_q, be_d;
   logic [31:0]        instr_q, instr_d;
   logic [BITSIZE-1:0] data_q, data_d;
   logic [BITSIZE-1:0] addr_q, addr_d;
   logic [BITSIZE-1:0] wdata_q, wdata_d;
   logic [1:0]         ofs_q, ofs_d;

   logic accept_c;
   logic done_c;

   // Opcode classification helpers.
   function automatic logic is_load(input logic [31:0] ins);
      return ins[OPC_W-1:0] == OPC_LOAD;
   endfunction

   function automatic logic is_store(input logic [31:0] ins);
      return ins[OPC_W-1:0] == OPC_STORE;
   endfunction

   // Byte enables for a store of the given size at byte offset a.
   function automatic logic [BE_W-1:0] store_be(input logic [F3_W-1:0] f3,
                                                input logic [1:0] a);
      logic [BE_W-1:0] be;
      case (f3)
         3'b000, 3'b100: be = BE_W'(4'b0001 << a);
         3'b001, 3'b101: be = a[1] ? 4'b1100 : 4'b0011;
         default:        be = 4'b1111;
      endcase
      return be;
   endfunction

   // Store data replicated across every lane it may land in.
   function automatic logic [BITSIZE-1:0] store_data(input logic [F3_W-1:0] f3,
                                                     input logic [BITSIZE-1:0] rs2);
      logic [BITSIZE-1:0] wd;
      case (f3)
         3'b000, 3'b100: wd = {4{rs2[7:0]}};
         3'b001, 3'b101: wd = {2{rs2[15:0]}};
         default:        wd = rs2;
      endcase
      return wd;
   endfunction

   // Select the addressed byte/half from the read word and extend it.
   function automatic logic [BITSIZE-1:0] load_ext(input logic [F3_W-1:0] f3,
                                                   input logic [1:0] a,
                                                   input logic [BITSIZE-1:0] rd);
      logic [7:0]         b;
      logic [15:0]        h;
      logic [BITSIZE-1:0] r;
      b = 8'(rd >> {a, 3'b000});
      h = a[1] ? rd[31:16] : rd[15:0];
      case (f3)
         3'b000:  r = {{(BITSIZE-8){b[7]}}, b};
         3'b100:  r = {{(BITSIZE-8){1'b0}}, b};
         3'b001:  r = {{(BITSIZE-16){h[15]}}, h};
         3'b101:  r = {{(BITSIZE-16){1'b0}}, h};
         default: r = rd;
      endcase
      return r;
   endfunction

   assign accept_c = (state_q == ST_GET) && get_q && EX_MEM_give_i;
   assign done_c   = (state_q == ST_ACCESS) && mem_ack_i;

   // State register.
   always_ff @(posedge clk or negedge resetn_i) begin
      if (!resetn_i) state_q <= ST_GET;
      else           state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_GET: begin
            if (accept_c) begin
               if (is_load(EX_MEM_instruction_i) || is_store(EX_MEM_instruction_i))
                  state_d = ST_ACCESS;
               else
                  state_d = ST_GIVE;
            end
         end
         ST_ACCESS: if (mem_ack_i) state_d = ST_GIVE;
         ST_GIVE:   if (WB_MEM_get_i && give_q) state_d = ST_GET;
         default:   state_d = ST_GET;
      endcase
   end

   // Handshake and bus-control outputs for the state being entered.
   always_comb begin
      get_d  = 1'b0;
      give_d = 1'b0;
      req_d  = 1'b0;
      we_d   = 1'b0;
      be_d   = '0;
      case (state_d)
         ST_GET:  get_d  = 1'b1;
         ST_GIVE: give_d = 1'b1;
         ST_ACCESS: begin
            req_d = 1'b1;
            if (is_store(instr_d)) begin
               we_d = 1'b1;
               be_d = store_be(instr_d[14:12], ofs_d);
            end
         end
         default: ;
      endcase
   end

   // Payload capture on accept and load-data capture on ack.
   always_comb begin
      instr_d = instr_q;
      data_d  = data_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      ofs_d   = ofs_q;
      if (accept_c) begin
         instr_d = EX_MEM_instruction_i;
         data_d  = EX_MEM_result_i;
         ofs_d   = EX_MEM_result_i[1:0];
         if (is_load(EX_MEM_instruction_i) || is_store(EX_MEM_instruction_i))
            addr_d = {EX_MEM_result_i[BITSIZE-1:2], 2'b00};
         if (is_store(EX_MEM_instruction_i))
            wdata_d = store_data(EX_MEM_instruction_i[14:12], EX_MEM_rs2_i);
      end
      if (done_c && is_load(instr_q))
         data_d = load_ext(instr_q[14:12], ofs_q, mem_rdata_i);
   end

   // Output and payload registers.
   always_ff @(posedge clk or negedge resetn_i) begin
      if (!resetn_i) begin
         get_q   <= 1'b0;
         give_q  <= 1'b0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         be_q    <= '0;
         instr_q <= '0;
         data_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         ofs_q   <= '0;
      end else begin
         get_q   <= get_d;
         give_q  <= give_d;
         req_q   <= req_d;
         we_q    <= we_d;
         be_q    <= be_d;
         instr_q <= instr_d;
         data_q  <= data_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         ofs_q   <= ofs_d;
      end
   end

   assign MEM_EX_get_o         = get_q;
   assign MEM_WB_give_o        = give_q;
   assign MEM_WB_instruction_o = instr_q;
   assign MEM_WB_data_o        = data_q;
   assign mem_req_o            = req_q;
   assign mem_we_o             = we_q;
   assign mem_be_o             = be_q;
   assign mem_addr_o           = addr_q;
   assign mem_wdata_o          = wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: passthrough, loads, stores, back-pressure, reset.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        resetn_i;
   logic        EX_MEM_give_i;
   logic        MEM_EX_get_o;
   logic [31:0] EX_MEM_instruction_i;
   logic [31:0] EX_MEM_result_i;
   logic [31:0] EX_MEM_rs2_i;
   logic        MEM_WB_give_o;
   logic        WB_MEM_get_i;
   logic [31:0] MEM_WB_instruction_o;
   logic [31:0] MEM_WB_data_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_rdata_i;
   logic        mem_ack_i;

   int checks = 0;
   int errors = 0;

   mem_stage #(.BITSIZE(32)) dut (
      .clk                  (clk),
      .resetn_i             (resetn_i),
      .EX_MEM_give_i        (EX_MEM_give_i),
      .MEM_EX_get_o         (MEM_EX_get_o),
      .EX_MEM_instruction_i (EX_MEM_instruction_i),
      .EX_MEM_result_i      (EX_MEM_result_i),
      .EX_MEM_rs2_i         (EX_MEM_rs2_i),
      .MEM_WB_give_o        (MEM_WB_give_o),
      .WB_MEM_get_i         (WB_MEM_get_i),
      .MEM_WB_instruction_o (MEM_WB_instruction_o),
      .MEM_WB_data_o        (MEM_WB_data_o),
      .mem_req_o            (mem_req_o),
      .mem_we_o             (mem_we_o),
      .mem_addr_o           (mem_addr_o),
      .mem_wdata_o          (mem_wdata_o),
      .mem_be_o             (mem_be_o),
      .mem_rdata_i          (mem_rdata_i),
      .mem_ack_i            (mem_ack_i)
   );

   always #5 clk = ~clk;

   // Advance one rising edge and settle just past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) until the stage is ready to accept.
   task automatic wait_get(input string name);
      int n = 0;
      while (MEM_EX_get_o !== 1'b1 && n < 8) begin
         tick();
         n++;
      end
      checks++;
      if (MEM_EX_get_o !== 1'b1) begin
         errors++;
         $display("FAIL %s wait_get: get=%b required 1", name, MEM_EX_get_o);
      end
   endtask

   task automatic test_reset();
      resetn_i = 1'b0;
      EX_MEM_give_i = 1'b0; EX_MEM_instruction_i = '0; EX_MEM_result_i = '0;
      EX_MEM_rs2_i = '0; WB_MEM_get_i = 1'b0; mem_rdata_i = '0; mem_ack_i = 1'b0;
      tick(); tick();
      checks++;
      if ({MEM_EX_get_o, MEM_WB_give_o, mem_req_o, mem_we_o, mem_be_o} !== 8'h00) begin
         errors++;
         $display("FAIL reset_ctrl: get/give/req/we/be=%b%b%b%b%b required 0000_0000",
                  MEM_EX_get_o, MEM_WB_give_o, mem_req_o, mem_we_o, mem_be_o);
      end
      checks++;
      if ({MEM_WB_instruction_o, MEM_WB_data_o, mem_addr_o, mem_wdata_o} !== 128'h0) begin
         errors++;
         $display("FAIL reset_regs: instr=%h data=%h addr=%h wdata=%h required 0",
                  MEM_WB_instruction_o, MEM_WB_data_o, mem_addr_o, mem_wdata_o);
      end
      resetn_i = 1'b1;
      wait_get("reset_release");
   endtask

   // Passthrough ALU op; hold_cycles of back-pressure with upstream give held.
   task automatic test_passthrough(input int hold_cycles, input logic up_give);
      EX_MEM_give_i = 1'b1;
      EX_MEM_instruction_i = 32'h0050_0093;
      EX_MEM_result_i = 32'h0000_0005;
      tick();
      EX_MEM_give_i = up_give;
      EX_MEM_instruction_i = 32'h0070_0113;
      EX_MEM_result_i = 32'hDEAD_BEEF;
      for (int i = 0; i <= hold_cycles; i++) begin
         checks++;
         if (MEM_EX_get_o !== 1'b0 || MEM_WB_give_o !== 1'b1 || mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL pass_hold%0d: get=%b give=%b req=%b required 0 1 0",
                     i, MEM_EX_get_o, MEM_WB_give_o, mem_req_o);
         end
         checks++;
         if (MEM_WB_data_o !== 32'h5 || MEM_WB_instruction_o !== 32'h0050_0093) begin
            errors++;
            $display("FAIL pass_data%0d: data=%h instr=%h required 00000005 00500093",
                     i, MEM_WB_data_o, MEM_WB_instruction_o);
         end
         if (i < hold_cycles) tick();
      end
      EX_MEM_give_i = 1'b0;
      WB_MEM_get_i = 1'b1;
      tick();
      WB_MEM_get_i = 1'b0;
      checks++;
      if (MEM_WB_give_o !== 1'b0 || MEM_EX_get_o !== 1'b1) begin
         errors++;
         $display("FAIL pass_handoff: give=%b get=%b required 0 1", MEM_WB_give_o, MEM_EX_get_o);
      end
   endtask

   task automatic test_load(input string name, input logic [2:0] f3, input logic [31:0] res,
                            input logic [31:0] rdata, input int waits, input logic [31:0] exp);
      logic [31:0] ins;
      ins = 32'h0000_0083 | (32'(f3) << 12);
      EX_MEM_give_i = 1'b1; EX_MEM_instruction_i = ins; EX_MEM_result_i = res;
      EX_MEM_rs2_i = 32'hFFFF_FFFF;
      tick();
      EX_MEM_give_i = 1'b0;
      for (int i = 0; i <= waits; i++) begin
         checks++;
         if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_be_o !== 4'b0000 ||
             mem_addr_o !== {res[31:2], 2'b00} || MEM_WB_give_o !== 1'b0) begin
            errors++;
            $display("FAIL %s req%0d: req=%b we=%b be=%b addr=%h give=%b required 1 0 0000 %h 0",
                     name, i, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, MEM_WB_give_o,
                     {res[31:2], 2'b00});
         end
         if (i == waits) begin
            mem_ack_i = 1'b1; mem_rdata_i = rdata;
         end
         tick();
      end
      mem_ack_i = 1'b0; mem_rdata_i = 32'h0BAD_0BAD;
      checks++;
      if (mem_req_o !== 1'b0 || MEM_WB_give_o !== 1'b1 || MEM_WB_data_o !== exp) begin
         errors++;
         $display("FAIL %s result: req=%b give=%b data=%h required 0 1 %h",
                  name, mem_req_o, MEM_WB_give_o, MEM_WB_data_o, exp);
      end
      WB_MEM_get_i = 1'b1; tick(); WB_MEM_get_i = 1'b0;
      wait_get(name);
   endtask

   task automatic test_store(input string name, input logic [2:0] f3, input logic [31:0] res,
                             input logic [31:0] rs2, input logic [3:0] exp_be,
                             input logic [31:0] exp_wd);
      logic [31:0] ins;
      ins = 32'h0000_0023 | (32'(f3) << 12);
      EX_MEM_give_i = 1'b1; EX_MEM_instruction_i = ins; EX_MEM_result_i = res;
      EX_MEM_rs2_i = rs2;
      tick();
      EX_MEM_give_i = 1'b0;
      checks++;
      if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_be_o !== exp_be ||
          mem_wdata_o !== exp_wd || mem_addr_o !== {res[31:2], 2'b00}) begin
         errors++;
         $display("FAIL %s bus: req=%b we=%b be=%b wdata=%h addr=%h required 1 1 %b %h %h",
                  name, mem_req_o, mem_we_o, mem_be_o, mem_wdata_o, mem_addr_o,
                  exp_be, exp_wd, {res[31:2], 2'b00});
      end
      mem_ack_i = 1'b1;
      tick();
      mem_ack_i = 1'b0;
      checks++;
      if (MEM_WB_give_o !== 1'b1 || mem_req_o !== 1'b0 || mem_we_o !== 1'b0 ||
          MEM_WB_data_o !== res) begin
         errors++;
         $display("FAIL %s done: give=%b req=%b we=%b data=%h required 1 0 0 %h",
                  name, MEM_WB_give_o, mem_req_o, mem_we_o, MEM_WB_data_o, res);
      end
      WB_MEM_get_i = 1'b1; tick(); WB_MEM_get_i = 1'b0;
      wait_get(name);
   endtask

   task automatic test_reset_mid_access();
      EX_MEM_give_i = 1'b1; EX_MEM_instruction_i = 32'h0000_2083;
      EX_MEM_result_i = 32'h0000_4000;
      tick();
      EX_MEM_give_i = 1'b0;
      tick();
      checks++;
      if (mem_req_o !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_pre: req=%b required 1", mem_req_o);
      end
      #2 resetn_i = 1'b0;
      #1;
      checks++;
      if (mem_req_o !== 1'b0 || MEM_WB_give_o !== 1'b0 || MEM_EX_get_o !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_drop: req=%b give=%b get=%b required 0 0 0",
                  mem_req_o, MEM_WB_give_o, MEM_EX_get_o);
      end
      tick();
      resetn_i = 1'b1;
      mem_ack_i = 1'b1; mem_rdata_i = 32'h1111_1111;
      tick();
      mem_ack_i = 1'b0;
      tick();
      checks++;
      if (MEM_WB_give_o !== 1'b0 || mem_req_o !== 1'b0) begin
         errors++;
         $display("FAIL rst_stray_ack: give=%b req=%b required 0 0", MEM_WB_give_o, mem_req_o);
      end
      wait_get("rst_recover");
      test_passthrough(0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_passthrough(3, 1'b0);
      test_load("lb",  3'b000, 32'h0000_1003, 32'h80AB_CD12, 2, 32'hFFFF_FF80);
      test_load("lbu", 3'b100, 32'h0000_1003, 32'h80AB_CD12, 2, 32'h0000_0080);
      test_load("lh",  3'b001, 32'h0000_2002, 32'hF00D_1234, 0, 32'hFFFF_F00D);
      test_load("lhu", 3'b101, 32'h0000_2002, 32'hF00D_1234, 1, 32'h0000_F00D);
      test_load("lhlo", 3'b001, 32'h0000_2001, 32'hF00D_9234, 0, 32'hFFFF_9234);
      test_load("lw",  3'b010, 32'h0000_2003, 32'hCAFE_F00D, 0, 32'hCAFE_F00D);
      test_store("sb", 3'b000, 32'h0000_3001, 32'h1234_56A5, 4'b0010, 32'hA5A5_A5A5);
      test_store("sh", 3'b001, 32'h0000_3002, 32'h1234_56A5, 4'b1100, 32'h56A5_56A5);
      test_store("sw", 3'b010, 32'h0000_3003, 32'h1234_56A5, 4'b1111, 32'h1234_56A5);
      test_passthrough(5, 1'b1);
      test_reset_mid_access();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage; consumes the executed instruction, ALU result and rs2 value.
- Performs data-memory loads and stores over a simple req/ack bus, with byte-lane steering and load sign/zero extension.
- Passes non-memory instructions through unchanged to the write-back stage.
- Uses the give/get handshake on both sides.

Parameters:
BITSIZE, 32, datapath width; this block supports only 32.

Ports:
clk  input  1  clock, rising edge
resetn_i  input  1  reset, asynchronous, active-low
EX_MEM_give_i  input  1  upstream has a valid instruction
MEM_EX_get_o  output  1  this stage can accept an instruction
EX_MEM_instruction_i  input  32  instruction word
EX_MEM_result_i  input  BITSIZE  ALU result (effective address for load/store)
EX_MEM_rs2_i  input  BITSIZE  store data
MEM_WB_give_o  output  1  result valid for write-back
WB_MEM_get_i  input  1  write-back can accept
MEM_WB_instruction_o  output  32  instruction word forwarded
MEM_WB_data_o  output  BITSIZE  load data or passthrough result
mem_req_o  output  1  memory request
mem_we_o  output  1  1 = write, 0 = read
mem_addr_o  output  BITSIZE  word-aligned address, {result[31:2],2'b00}
mem_wdata_o  output  BITSIZE  lane-shifted store data
mem_be_o  output  4  byte enables
mem_rdata_i  input  BITSIZE  read data word
mem_ack_i  input  1  request completed this cycle

Behaviour:
- Handshakes
  - A transfer occurs at a rising edge where give and get are both high.
  - Give/get must not depend combinationally on the partner's signal, so no loops.
- FSM states: GET, ACCESS, GIVE. All state and payload registers are flopped.
- Reset (asynchronous, resetn_i low)
  - State goes to GET.
  - MEM_EX_get_o=0 while reset is asserted.
  - MEM_WB_give_o=0, mem_req_o=0, mem_we_o=0, mem_be_o=0.
  - Instruction, data, addr and wdata registers are cleared to 0.
  - Reset during ACCESS abandons the request; a later mem_ack_i is ignored unless in ACCESS.
- GET
  - MEM_EX_get_o=1.
  - On transfer, latch instruction, result and rs2.
  - Opcode[6:0]=0000011 (LOAD) or 0100011 (STORE): go to ACCESS.
  - Any other opcode: data register is loaded with the result; go to GIVE.
- ACCESS
  - mem_req_o=1; addr, we, be and wdata are held stable until ack.
  - Sample mem_ack_i at each edge. On ack:
    - Load: latch the extended read data; go to GIVE.
    - Store: data register is loaded with the result; go to GIVE.
  - No timeout.
- GIVE
  - MEM_WB_give_o=1; outputs are stable.
  - On WB_MEM_get_i: go to GET.
  - No new instruction is accepted before the hand-off (single-entry stage).
- Latency
  - Passthrough: accepted at edge N, give high from cycle N+1.
  - Memory: req high from cycle N+1; ack sampled at edge M; give high from cycle M+1.
  - Zero-wait memory (ack in the first req cycle): give at N+2.
- Byte lanes, where a = result[1:0] and funct3 = instruction[14:12]
  - Byte (funct3 000/100): be = 4'b0001<<a; wdata = {4{rs2[7:0]}}.
  - Half (001/101): address bit 0 is ignored; be = a[1] ? 1100 : 0011; wdata = {2{rs2[15:0]}}.
  - Word (010): be = 1111; wdata = rs2; a is ignored.
  - Other funct3 values: treated as word.
  - Misalignment is not trapped.
- Load extension
  - The selected byte/half from rdata is shifted to bit 0.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the full word.
- Other rules
  - Stores never modify MEM_WB_data_o semantics (it carries the address).
  - mem_we_o is valid only while mem_req_o is high, else 0.

Test Plan:
- Passthrough: ADDI (0x00500093) with result 0x5 → get low at N+1, give high at N+1 with data 0x5; held until WB_MEM_get_i is pulsed 3 cycles later; back to GET.
- LB sign: LB from result 0x1003, rdata 0x80AB_CD12, ack after 2 wait cycles → addr 0x1000, be 0000 (read), req held 3 cycles; data 0xFFFFFF80. LBU same → 0x00000080.
- LH/LHU: result 0x2002, rdata 0xF00D_1234 → LH 0xFFFFF00D, LHU 0x0000F00D.
- Stores: SB result 0x3001, rs2 0x1234_56A5 → be 0010, wdata 0xA5A5A5A5. SH result 0x3002 → be 1100, wdata 0x56A556A5. SW → be 1111, wdata 0x123456A5.
- Back-pressure: WB_MEM_get_i low for 5 cycles in GIVE → outputs stable and MEM_EX_get_o low throughout, even while EX_MEM_give_i is high.
- Reset mid-access: deassert resetn_i while in ACCESS with no ack → req and give drop to 0 immediately. After release, a stray ack causes no give, and the next instruction is accepted normally.
